serial_subtractor: RTL and testbench

Bit-serial, multi-cycle N-bit subtractor: the inverse-direction companion to the combinational adder in the arithmetic library. It accepts two operands on a start pulse, processes one bit per clock LSB-first through a single full-subtractor cell, then presents difference, borrow and signed-overflow flags with a one-cycle done pulse. It is intended for area-constrained datapaths where an N-bit parallel subtract is not justified.

---
 rtl/serial_subtractor.sv | 124 ++++++++++++
 tb/tb_serial_subtractor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first N-bit subtractor: one full-subtractor cell, N cycles per result.
// Define SERIAL_SUB_ADD_EN to add the op port (0 = subtract, 1 = add).
module serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
`ifdef SERIAL_SUB_ADD_EN
  input  logic         op,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] d,
  output logic         borrow,
  output logic         overflow
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_x;
  logic [N-1:0]   r_y;
  logic [CW-1:0]  r_cnt;
  logic           r_b;
  logic [N-1:0]   r_d;
  logic           r_borrow;
  logic           r_ovf;

  logic           w_xi;
  logic           w_yi;
  logic           w_bit;
  logic           w_b_nxt;
  logic           w_last;
  logic           w_accept;

  assign w_xi     = r_x[0];
  assign w_yi     = r_y[0];
  assign w_bit    = w_xi ^ w_yi ^ r_b;
  assign w_last   = (r_cnt == CW'(N - 1));
  assign w_accept = start && (r_state != S_RUN);

`ifdef SERIAL_SUB_ADD_EN
  logic r_op;

  assign w_b_nxt = r_op ? ((w_xi & w_yi) | ((w_xi ^ w_yi) & r_b))
                        : ((~w_xi & w_yi) | (~(w_xi ^ w_yi) & r_b));
`else
  assign w_b_nxt = (~w_xi & w_yi) | (~(w_xi ^ w_yi) & r_b);
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Result bits shift into the vacated MSB of the minuend register, so after
  // N shifts r_x holds the difference; the final load merges the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x      <= '0;
      r_y      <= '0;
      r_cnt    <= '0;
      r_b      <= 1'b0;
      r_d      <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_x   <= x;
      r_y   <= y;
      r_cnt <= '0;
      r_b   <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_x   <= {w_bit, r_x[N-1:1]};
      r_y   <= {1'b0, r_y[N-1:1]};
      r_b   <= w_b_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_d      <= {w_bit, r_x[N-1:1]};
        r_borrow <= w_b_nxt;
        r_ovf    <= r_b ^ w_b_nxt;
      end
    end
  end

`ifdef SERIAL_SUB_ADD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= 1'b0;
    end else if (w_accept) begin
      r_op <= op;
    end
  end
`endif

  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign d        = r_d;
  assign borrow   = r_borrow;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus randomized
// operations checked against an integer-arithmetic reference model.
module tb_serial_subtractor;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         op;
  logic         busy;
  logic         done;
  logic [N-1:0] d;
  logic         borrow;
  logic         overflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [N-1:0] cur_d;
  logic         cur_b;
  logic         cur_v;

  serial_subtractor #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .x        (x),
    .y        (y),
`ifdef SERIAL_SUB_ADD_EN
    .op       (op),
`endif
    .busy     (busy),
    .done     (done),
    .d        (d),
    .borrow   (borrow),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b, input logic o,
                                output logic [N-1:0] md, output logic mb, output logic mv);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(a);
    ub = int'(b);
    sa = a[N-1] ? ua - (1 << N) : ua;
    sb = b[N-1] ? ub - (1 << N) : ub;
    if (o) begin
      ur = ua + ub;
      sr = sa + sb;
      mb = (ur >= (1 << N));
    end else begin
      ur = ua - ub;
      sr = sa - sb;
      mb = (ua < ub);
    end
    md = N'(ur);
    mv = (sr > (1 << (N - 1)) - 1) || (sr < -(1 << (N - 1)));
  endfunction

  // Drives a start for the next active edge and returns #1 after it.
  task automatic accept_now(input logic [N-1:0] a, input logic [N-1:0] b, input logic o);
    start = 1'b1;
    x     = a;
    y     = b;
    op    = o;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
    chk("done_after_accept", done, 1'b0);
  endtask

  // Called #1 after the accepting edge; returns #1 after the done edge.
  task automatic wait_result(input logic [N-1:0] a, input logic [N-1:0] b, input logic o,
                             input bit disturb);
    logic [N-1:0] md;
    logic mb, mv;
    int k;
    model(a, b, o, md, mb, mv);
    k = 0;
    while (!done && k < 3 * N) begin
      chk("d_hold", d, cur_d);
      chk("borrow_hold", borrow, cur_b);
      chk("ovf_hold", overflow, cur_v);
      if (disturb) begin
        start = 1'($urandom_range(0, 1));
        x     = N'($urandom);
        y     = N'($urandom);
      end
      @(posedge clk);
      #1;
      k++;
    end
    start = 1'b0;
    chk("latency", k, N);
    chk("done", done, 1'b1);
    chk("busy_in_done", busy, 1'b0);
    chk("d", d, md);
    chk("borrow", borrow, mb);
    chk("overflow", overflow, mv);
    cur_d = md;
    cur_b = mb;
    cur_v = mv;
  endtask

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic o,
                       input bit disturb);
    @(negedge clk);
    accept_now(a, b, o);
    wait_result(a, b, o, disturb);
    @(posedge clk);
    #1;
    chk("done_single_pulse", done, 1'b0);
    chk("idle_after_done", busy, 1'b0);
    chk("d_hold_idle", d, cur_d);
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    logic ro;

    rst_n = 1'b0;
    start = 1'b0;
    x     = '0;
    y     = '0;
    op    = 1'b0;
    cur_d = '0;
    cur_b = 1'b0;
    cur_v = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_d", d, '0);
    chk("rst_borrow", borrow, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(4'b0111, 4'b0011, 1'b0, 1'b0);
    do_op(4'b0011, 4'b0111, 1'b0, 1'b0);

    // Back-to-back: start held in the done cycle.
    @(negedge clk);
    accept_now(4'b1000, 4'b0001, 1'b0);
    wait_result(4'b1000, 4'b0001, 1'b0, 1'b0);
    accept_now(4'b0111, 4'b1111, 1'b0);
    wait_result(4'b0111, 4'b1111, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("b2b_done_single", done, 1'b0);

    // Mid-run start pulses and operand changes are ignored.
    do_op(4'b0101, 4'b1010, 1'b0, 1'b1);
    do_op(4'b1110, 4'b0011, 1'b0, 1'b1);

    // Reset at bit 2 of an operation.
    @(negedge clk);
    accept_now(4'b0001, 4'b0010, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_d", d, '0);
    chk("midrst_borrow", borrow, 1'b0);
    chk("midrst_ovf", overflow, 1'b0);
    cur_d = '0;
    cur_b = 1'b0;
    cur_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_done", done, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(4'b0110, 4'b0010, 1'b0, 1'b0);

`ifdef SERIAL_SUB_ADD_EN
    do_op(4'b0111, 4'b0001, 1'b1, 1'b0);
    do_op(4'b1111, 4'b0001, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 24; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
`ifdef SERIAL_SUB_ADD_EN
      ro = 1'($urandom_range(0, 1));
`else
      ro = 1'b0;
`endif
      do_op(ra, rb, ro, bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
